// File: rtl/fifo_pack_pkg.sv
// Shared constants and helpers for the FIFO read-side packer.
// keep_mask builds the per-lane valid mask for a word holding cnt entries.
package fifo_pack_pkg;

    localparam int DEF_IN_WIDTH = 8;
    localparam int DEF_PACK     = 4;
    localparam int MAX_PACK     = 64;

    typedef logic [$clog2(DEF_PACK + 1) - 1:0] lane_cnt_t;

    function automatic logic [MAX_PACK-1:0] keep_mask(input int unsigned cnt);
        logic [MAX_PACK-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_PACK; i++) begin
            if (unsigned'(i) < cnt) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Counts idle cycles of a partially filled word and pulses expire_o on the
// cycle the count reaches TIMEOUT. With TIMEOUT=0 expire_o never fires.
module pack_idle_timer #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam bit        ACTIVE = (TIMEOUT > 0);
    localparam int        TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;
    logic          step;

    assign step     = ACTIVE && en_i && !clr_i;
    assign expire_o = step && (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clr_i || expire_o) begin
            count_d = '0;
        end else if (step) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a registered-read FIFO and packs PACK entries per output beat.
// Lane 0 holds the oldest entry; a blocked complete word waits in the accumulator.
module fifo_rd_packer
    import fifo_pack_pkg::*;
#(
    parameter  int IN_WIDTH  = DEF_IN_WIDTH,
    parameter  int PACK      = DEF_PACK,
    parameter  int TIMEOUT   = 0,
    localparam int OUT_WIDTH = IN_WIDTH * PACK
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [PACK-1:0]      out_keep
);

    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [CW-1:0]                    cnt_q, cnt_d, cnt_cap;
    logic [PACK-1:0][IN_WIDTH-1:0]    acc_q, acc_d, acc_cap;
    logic                             rd_pending_q;
    logic                             acc_full_q, acc_full_d;
    logic                             out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]             out_data_q, out_data_d;
    logic [PACK-1:0]                  out_keep_q, out_keep_d;

    logic last_cap, complete, out_free, load;
    logic tmr_clr, tmr_en, tmr_expire;

    // Stop issuing when the read in flight will complete a word that cannot leave.
    assign fifo_rd_en = rst_n && !fifo_empty && !acc_full_q &&
                        !(rd_pending_q && cnt_q == LAST && out_valid_q && !out_ready);

    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        assign acc_cap[gi] = (rd_pending_q && cnt_q == CW'(gi)) ? fifo_rd_data : acc_q[gi];
    end

    assign cnt_cap  = cnt_q + {{(CW-1){1'b0}}, rd_pending_q};
    assign last_cap = rd_pending_q && (cnt_q == LAST);

    assign tmr_clr = rd_pending_q || fifo_rd_en || acc_full_q;
    assign tmr_en  = (cnt_q != '0) && !rd_pending_q && !fifo_rd_en && !acc_full_q;

    pack_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    assign complete = last_cap || tmr_expire;
    assign out_free = !out_valid_q || out_ready;
    assign load     = out_free && (acc_full_q || complete);

    always_comb begin
        acc_d       = acc_cap;
        cnt_d       = cnt_cap;
        acc_full_d  = acc_full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        if (load) begin
            // Unused lanes are already zero because the accumulator clears on every load.
            out_data_d  = acc_cap;
            out_keep_d  = PACK'(keep_mask(32'(cnt_cap)));
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            acc_full_d  = 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (complete) begin
                acc_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            rd_pending_q <= 1'b0;
            acc_full_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            rd_pending_q <= fifo_rd_en;
            acc_full_q   <= acc_full_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench: queue-based FIFO and packer model compared every cycle,
// plus literal expectations for streaming, backpressure, sparse, timeout and reset.
module tb_fifo_rd_packer;

    localparam int IW = 8;
    localparam int PK = 4;
    localparam int TO = 8;
    localparam int OW = IW * PK;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [IW-1:0] fifo_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [PK-1:0] out_keep;

    always #5 clk = ~clk;

    fifo_rd_packer #(
        .IN_WIDTH (IW),
        .PACK     (PK),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_keep     (out_keep)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    byte unsigned fifo_q[$];
    byte unsigned popped[$];
    byte unsigned delivered[$];
    bit           pop_next = 1'b0;
    byte unsigned pop_val  = 8'h00;

    // Model: bytes held in the accumulator, a held-word flag, and the output slot.
    byte unsigned  m_acc[$];
    bit            m_held, m_valid, m_pending;
    logic [OW-1:0] m_data;
    logic [PK-1:0] m_keep;
    int            m_idle;
    byte unsigned  m_rd_val;

    int            first_rd, first_valid, last_cap, rd_count, rd_run, rd_run_max;
    logic [OW-1:0] beat_data[$];
    logic [PK-1:0] beat_keep[$];
    int            beat_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] beat_at(input int i);
        if (i < beat_data.size()) return beat_data[i];
        return 'x;
    endfunction

    function automatic logic [PK-1:0] keep_at(input int i);
        if (i < beat_keep.size()) return beat_keep[i];
        return 'x;
    endfunction

    task automatic phase_reset();
        m_acc.delete();
        m_held = 0; m_valid = 0; m_pending = 0;
        m_data = '0; m_keep = '0; m_idle = 0; m_rd_val = 0;
        fifo_q.delete(); popped.delete(); delivered.delete();
        beat_data.delete(); beat_keep.delete(); beat_cyc.delete();
        first_rd = -1; first_valid = -1; last_cap = -1;
        rd_count = 0; rd_run = 0; rd_run_max = 0;
        pop_next = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_empty = 1'b0;
        phase_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst(input bit chk);
        fifo_empty = (fifo_q.size() == 0);
        rst_n = 1'b1;
        #1;
        if (chk) check("release_rd_en", fifo_rd_en, 1);
    endtask

    task automatic check_stream();
        int bad = 0;
        check("stream_len", delivered.size(), popped.size());
        foreach (delivered[i]) begin
            if (i >= popped.size() || delivered[i] != popped[i]) bad++;
        end
        check("stream_order", bad, 0);
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit rdy, input bit hide);
        bit            exp_rd, transfer, captured, fire, complete;
        int            n;
        out_ready    = rdy;
        fifo_empty   = hide || (fifo_q.size() == 0);
        fifo_rd_data = pop_next ? pop_val : IW'($urandom);
        m_rd_val     = pop_next ? pop_val : 8'h00;
        pop_next     = 0;
        @(negedge clk);

        exp_rd = !fifo_empty && !m_held &&
                 !(m_pending && m_acc.size() == PK - 1 && m_valid && !out_ready);
        check("rd_en", fifo_rd_en, exp_rd);
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_keep", out_keep, m_keep);

        if (fifo_rd_en && fifo_q.size() > 0) begin
            pop_val  = fifo_q.pop_front();
            popped.push_back(pop_val);
            pop_next = 1;
        end
        if (fifo_rd_en) begin
            rd_count++;
            rd_run++;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
            if (first_rd < 0) first_rd = cyc;
        end else begin
            rd_run = 0;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            beat_data.push_back(out_data);
            beat_keep.push_back(out_keep);
            beat_cyc.push_back(cyc);
            for (int i = 0; i < PK; i++)
                if (out_keep[i]) delivered.push_back(out_data[IW*i +: IW]);
            $display("beat %0d at cycle %0d: data=%h keep=%b", beat_data.size() - 1, cyc, out_data, out_keep);
        end

        transfer = m_valid && out_ready;
        captured = m_pending;
        if (captured) begin
            m_acc.push_back(m_rd_val);
            last_cap = cyc;
        end
        fire = (TO > 0) && !captured && !exp_rd && !m_held && m_acc.size() > 0 && (m_idle + 1 == TO);
        complete = m_held || (captured && m_acc.size() == PK) || fire;
        if (complete) begin
            if (!m_valid || out_ready) begin
                n = m_acc.size();
                m_data = '0;
                m_keep = '0;
                for (int i = 0; i < n; i++) begin
                    m_data = m_data | (OW'(m_acc[i]) << (IW * i));
                    m_keep[i] = 1'b1;
                end
                m_acc.delete();
                m_valid = 1;
                m_held  = 0;
            end else begin
                m_held = 1;
            end
        end else if (transfer) begin
            m_valid = 0;
        end
        if (captured || exp_rd || m_held || m_acc.size() == 0) m_idle = 0;
        else m_idle++;
        m_pending = exp_rd;

        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int streak;
        bit hide;
        int full_beats;

        // Reset with a non-empty FIFO.
        phase_reset();
        rst_n = 1'b0;
        fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_keep", out_keep, 0);

        // Streaming.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(byte'(8'h11 * i));
        release_rst(1);
        repeat (20) cycle(1, 0);
        check("stream_beats", beat_data.size(), 2);
        check("stream_beat0", beat_at(0), 32'h44332211);
        check("stream_keep0", keep_at(0), 4'hF);
        check("stream_beat1", beat_at(1), 32'h88776655);
        check("stream_keep1", keep_at(1), 4'hF);
        check("stream_gap", (beat_cyc.size() >= 2) ? beat_cyc[1] - beat_cyc[0] : -1, 4);
        check("stream_latency", first_valid - first_rd, 5);
        check("stream_rd_run", rd_run_max, 8);
        check_stream();

        // Backpressure.
        do_reset();
        for (int i = 0; i < 12; i++) fifo_q.push_back(byte'(8'hB0 + i));
        release_rst(0);
        repeat (20) cycle(0, 0);
        check("bp_reads", rd_count, 8);
        check("bp_rd_en_idle", fifo_rd_en, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, 32'hB3B2B1B0);
        repeat (20) cycle(1, 0);
        check("bp_beats", beat_data.size(), 3);
        check("bp_beat0", beat_at(0), 32'hB3B2B1B0);
        check("bp_beat1", beat_at(1), 32'hB7B6B5B4);
        check("bp_beat2", beat_at(2), 32'hBBBAB9B8);
        check_stream();

        // Sparse input with random backpressure; empty gaps kept short of the timeout.
        do_reset();
        for (int i = 0; i < 64; i++) fifo_q.push_back(byte'(i));
        release_rst(0);
        streak = 0;
        for (int i = 0; i < 2000 && beat_data.size() < 16; i++) begin
            hide = (streak < 3) ? bit'($urandom_range(1)) : 1'b0;
            streak = hide ? streak + 1 : 0;
            cycle(($urandom_range(3) != 0), hide);
        end
        repeat (4) cycle(1, 0);
        full_beats = 0;
        foreach (beat_keep[i]) if (beat_keep[i] == 4'hF) full_beats++;
        check("sparse_beats", beat_data.size(), 16);
        check("sparse_full_keep", full_beats, 16);
        check_stream();

        // Timeout flush of a partial word.
        do_reset();
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hB2);
        fifo_q.push_back(8'hC3);
        release_rst(0);
        repeat (25) cycle(1, 0);
        check("to_beats", beat_data.size(), 1);
        check("to_data", beat_at(0), 32'h00C3B2A1);
        check("to_keep", keep_at(0), 4'b0111);
        check("to_delay", first_valid - last_cap, 9);
        check_stream();

        // Reset mid-word discards the partial word.
        do_reset();
        fifo_q.push_back(8'hEE);
        fifo_q.push_back(8'hFF);
        release_rst(0);
        repeat (4) cycle(1, 0);
        do_reset();
        for (int i = 1; i <= 4; i++) fifo_q.push_back(byte'(i));
        release_rst(0);
        repeat (15) cycle(1, 0);
        check("mid_beats", beat_data.size(), 1);
        check("mid_data", beat_at(0), 32'h04030201);
        check("mid_keep", keep_at(0), 4'hF);
        check_stream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
